mips_control_unit: RTL and testbench



---
 rtl/mips_control_unit.sv | 137 +++++++++++++
 tb/tb_mips_control_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mips_control_unit.sv
// MIPS ID-stage main decoder: opcode/funct to datapath controls, plus a sticky illegal flag.
// Decode is zero-cycle combinational with no handshake; illegal_seen registers on clk.
module mips_control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [1:0] reg_dst,
    output logic       branch,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_to_reg,
    output logic [3:0] alu_op,
    output logic       alu_src,
    output logic       reg_write,
    output logic       jump,
    output logic [1:0] imm_ext,
    output logic       illegal_op,
    output logic       illegal_seen
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic [3:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
        logic [1:0] imm_ext;
    } ctrl_t;

    ctrl_t ctrl;
    logic  illegal;

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (opcode)
            6'b000000: begin
                ctrl.reg_dst   = 2'b01;
                ctrl.reg_write = 1'b1;
                case (funct)
                    6'b100000, 6'b100001: ctrl.alu_op = ALU_ADD;
                    6'b100010, 6'b100011: ctrl.alu_op = ALU_SUB;
                    6'b100100:            ctrl.alu_op = ALU_AND;
                    6'b100101:            ctrl.alu_op = ALU_OR;
                    6'b100110:            ctrl.alu_op = ALU_XOR;
                    6'b100111:            ctrl.alu_op = ALU_NOR;
                    6'b101010:            ctrl.alu_op = ALU_SLT;
                    6'b101011:            ctrl.alu_op = ALU_SLTU;
                    6'b000000:            ctrl.alu_op = ALU_SLL;
                    6'b000010:            ctrl.alu_op = ALU_SRL;
                    6'b000011:            ctrl.alu_op = ALU_SRA;
                    default: begin
                        // Unknown funct becomes a bubble, not a partial R-type.
                        ctrl    = '0;
                        illegal = 1'b1;
                    end
                endcase
            end
            6'b100011: begin
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 2'b01;
                ctrl.alu_op     = ALU_ADD;
                ctrl.alu_src    = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            6'b101011: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
            end
            6'b000100: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            6'b000010: ctrl.jump = 1'b1;
            6'b000011: begin
                ctrl.jump       = 1'b1;
                ctrl.reg_dst    = 2'b10;
                ctrl.mem_to_reg = 2'b10;
                ctrl.reg_write  = 1'b1;
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                case (opcode[2:0])
                    3'b010:  ctrl.alu_op = ALU_SLT;
                    3'b011:  ctrl.alu_op = ALU_SLTU;
                    3'b100: begin ctrl.alu_op = ALU_AND; ctrl.imm_ext = 2'b01; end
                    3'b101: begin ctrl.alu_op = ALU_OR;  ctrl.imm_ext = 2'b01; end
                    3'b110: begin ctrl.alu_op = ALU_XOR; ctrl.imm_ext = 2'b01; end
                    // LUI adds the shifted immediate to rs=$0.
                    3'b111: begin ctrl.alu_op = ALU_ADD; ctrl.imm_ext = 2'b10; end
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    assign reg_dst    = ctrl.reg_dst;
    assign branch     = ctrl.branch;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_op     = ctrl.alu_op;
    assign alu_src    = ctrl.alu_src;
    assign reg_write  = ctrl.reg_write;
    assign jump       = ctrl.jump;
    assign imm_ext    = ctrl.imm_ext;
    assign illegal_op = illegal;

    always_ff @(posedge clk) begin
        if (rst)
            illegal_seen <= 1'b0;
        else if (illegal)
            illegal_seen <= 1'b1;
    end

endmodule

// File: tb/tb_mips_control_unit.sv
// Self-checking bench for mips_control_unit: scoreboarded decode vectors and sticky-flag checks.
module tb_mips_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [1:0] reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic [3:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic [1:0] imm_ext;
    logic       illegal_op;
    logic       illegal_seen;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [16:0] exp;
    } sb_t;
    sb_t sb[$];

    mips_control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .reg_dst(reg_dst), .branch(branch), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
        .alu_src(alu_src), .reg_write(reg_write), .jump(jump),
        .imm_ext(imm_ext), .illegal_op(illegal_op), .illegal_seen(illegal_seen)
    );

    always #5 clk = ~clk;

    logic [16:0] obs_v;
    assign obs_v = {reg_dst, branch, mem_read, mem_write, mem_to_reg, alu_op,
                    alu_src, reg_write, jump, imm_ext, illegal_op};

    function automatic logic [16:0] pk(input logic [1:0] rd, input logic br,
                                       input logic mr, input logic mw,
                                       input logic [1:0] m2r, input logic [3:0] op,
                                       input logic src, input logic rw,
                                       input logic j, input logic [1:0] ie,
                                       input logic ill);
        return {rd, br, mr, mw, m2r, op, src, rw, j, ie, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [16:0] exp);
        sb_t e;
        @(negedge clk);
        opcode = op;
        funct  = fn;
        e.tag  = tag;
        e.exp  = exp;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        check(e.tag, {15'b0, obs_v}, {15'b0, e.exp});
    endtask

    task automatic seen_chk(input string tag, input logic exp);
        @(negedge clk);
        #1;
        check(tag, {31'b0, illegal_seen}, {31'b0, exp});
    endtask

    initial begin
        logic [16:0] ill_v;
        ill_v  = pk(2'b00, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 2'b00, 1);
        rst    = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b000000;
        repeat (2) @(posedge clk);
        // Decode must be live while reset is held.
        drive("rst_sll", 6'b000000, 6'b000000, pk(2'b01, 0, 0, 0, 2'b00, 4'b1000, 0, 1, 0, 2'b00, 0));
        seen_chk("rst_seen", 1'b0);
        rst = 1'b0;

        drive("r_add",  6'b000000, 6'b100000, pk(2'b01, 0, 0, 0, 2'b00, 4'b0010, 0, 1, 0, 2'b00, 0));
        drive("r_addu", 6'b000000, 6'b100001, pk(2'b01, 0, 0, 0, 2'b00, 4'b0010, 0, 1, 0, 2'b00, 0));
        drive("r_sub",  6'b000000, 6'b100010, pk(2'b01, 0, 0, 0, 2'b00, 4'b0110, 0, 1, 0, 2'b00, 0));
        drive("r_nor",  6'b000000, 6'b100111, pk(2'b01, 0, 0, 0, 2'b00, 4'b1100, 0, 1, 0, 2'b00, 0));
        drive("r_and",  6'b000000, 6'b100100, pk(2'b01, 0, 0, 0, 2'b00, 4'b0000, 0, 1, 0, 2'b00, 0));
        drive("r_xor",  6'b000000, 6'b100110, pk(2'b01, 0, 0, 0, 2'b00, 4'b0011, 0, 1, 0, 2'b00, 0));
        drive("r_sltu", 6'b000000, 6'b101011, pk(2'b01, 0, 0, 0, 2'b00, 4'b1011, 0, 1, 0, 2'b00, 0));
        drive("r_srl",  6'b000000, 6'b000010, pk(2'b01, 0, 0, 0, 2'b00, 4'b1001, 0, 1, 0, 2'b00, 0));
        drive("r_sra",  6'b000000, 6'b000011, pk(2'b01, 0, 0, 0, 2'b00, 4'b1010, 0, 1, 0, 2'b00, 0));
        drive("lw",     6'b100011, 6'b001111, pk(2'b00, 0, 1, 0, 2'b01, 4'b0010, 1, 1, 0, 2'b00, 0));
        drive("sw",     6'b101011, 6'b000000, pk(2'b00, 0, 0, 1, 2'b00, 4'b0010, 1, 0, 0, 2'b00, 0));
        drive("beq",    6'b000100, 6'b000000, pk(2'b00, 1, 0, 0, 2'b00, 4'b0110, 0, 0, 0, 2'b00, 0));
        drive("j",      6'b000010, 6'b000000, pk(2'b00, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 1, 2'b00, 0));
        drive("jal",    6'b000011, 6'b000000, pk(2'b10, 0, 0, 0, 2'b10, 4'b0000, 0, 1, 1, 2'b00, 0));
        drive("addi",   6'b001000, 6'b000000, pk(2'b00, 0, 0, 0, 2'b00, 4'b0010, 1, 1, 0, 2'b00, 0));
        drive("addiu",  6'b001001, 6'b000000, pk(2'b00, 0, 0, 0, 2'b00, 4'b0010, 1, 1, 0, 2'b00, 0));
        drive("slti",   6'b001010, 6'b000000, pk(2'b00, 0, 0, 0, 2'b00, 4'b0111, 1, 1, 0, 2'b00, 0));
        drive("sltiu",  6'b001011, 6'b000000, pk(2'b00, 0, 0, 0, 2'b00, 4'b1011, 1, 1, 0, 2'b00, 0));
        drive("andi",   6'b001100, 6'b000000, pk(2'b00, 0, 0, 0, 2'b00, 4'b0000, 1, 1, 0, 2'b01, 0));
        drive("ori",    6'b001101, 6'b000000, pk(2'b00, 0, 0, 0, 2'b00, 4'b0001, 1, 1, 0, 2'b01, 0));
        drive("xori",   6'b001110, 6'b000000, pk(2'b00, 0, 0, 0, 2'b00, 4'b0011, 1, 1, 0, 2'b01, 0));
        drive("lui",    6'b001111, 6'b000000, pk(2'b00, 0, 0, 0, 2'b00, 4'b0010, 1, 1, 0, 2'b10, 0));
        seen_chk("seen_clean", 1'b0);

        drive("ill_op", 6'b111111, 6'b100000, ill_v);
        seen_chk("seen_set", 1'b1);
        drive("ill_fn", 6'b000000, 6'b001111, ill_v);
        drive("post_add", 6'b000000, 6'b100000, pk(2'b01, 0, 0, 0, 2'b00, 4'b0010, 0, 1, 0, 2'b00, 0));
        drive("post_lw",  6'b100011, 6'b000000, pk(2'b00, 0, 1, 0, 2'b01, 4'b0010, 1, 1, 0, 2'b00, 0));
        seen_chk("seen_sticky", 1'b1);

        // Reset wins over an illegal opcode on the same edge.
        @(negedge clk);
        rst    = 1'b1;
        opcode = 6'b111111;
        funct  = 6'b000000;
        @(negedge clk);
        #1;
        check("rst_prio_seen", {31'b0, illegal_seen}, 32'd0);
        check("rst_prio_ill",  {31'b0, illegal_op},   32'd1);
        rst    = 1'b0;
        opcode = 6'b100011;
        seen_chk("rst_hold", 1'b0);

        for (int op = 0; op < 64; op++) begin
            logic [5:0] o;
            logic       legal;
            o = 6'(op);
            legal = (o inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd35, 6'd43}) ||
                    (o >= 6'd8 && o <= 6'd15);
            @(negedge clk);
            opcode = o;
            funct  = 6'b100000;
            #1;
            check($sformatf("sweep_x_%0d", op), {31'b0, $isunknown({obs_v, illegal_seen})}, 32'd0);
            check($sformatf("sweep_ill_%0d", op), {31'b0, illegal_op}, {31'b0, ~legal});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
